// File: rtl/rr_arbiter_fsm_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_pkg
// Purpose  : Shared definitions for the round-robin arbiter. Holds the FSM
//            state encodings, the default configuration constants and a
//            helper that sizes index fields.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package rr_arb_pkg;

  localparam int DEFAULT_N        = 4;
  localparam int DEFAULT_MAX_HOLD = 8;

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_GRANT   = 2'b01,
    S_RECOVER = 2'b10
  } state_t;

  // Width of an index into a set of n items. Never returns zero, so a
  // degenerate n still produces a legal vector.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter_fsm_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_fsm_if
// Purpose  : Bundles the requester-facing signals of the round-robin arbiter.
// Ports    : req     - one level-held request line per requester
//            grant   - registered one-hot (or zero) grant
//            owner   - index of the current or last granted requester
//            busy    - high while the arbiter is in GRANT
//            state   - current FSM state, for observation
//            timeout - one-cycle pulse on a forced release
// Modports : master - requester side (drives req)
//            slave  - arbiter side (drives everything else)
// Revision : 1.0 - initial release
// ============================================================================
interface rr_arbiter_fsm_if
  import rr_arb_pkg::*;
#(
  parameter int N = DEFAULT_N
);

  localparam int OW = idx_w(N);

  logic [N-1:0]  req;
  logic [N-1:0]  grant;
  logic [OW-1:0] owner;
  logic          busy;
  logic [1:0]    state;
  logic          timeout;

  modport master (
    output req,
    input  grant, owner, busy, state, timeout
  );

  modport slave (
    input  req,
    output grant, owner, busy, state, timeout
  );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter_fsm_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin selector. Finds the first asserted
//            request searching ptr, ptr+1, ... modulo N.
// Ports    : req    - request vector
//            ptr    - index where the search starts
//            winner - index of the selected requester (0 when none)
//            valid  - high when at least one request is asserted
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick
  import rr_arb_pkg::*;
#(
  parameter  int N  = DEFAULT_N,
  localparam int OW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [OW-1:0] ptr,
  output logic [OW-1:0] winner,
  output logic          valid
);

  // cand[k] is the requester index visited k steps after ptr.
  logic [OW-1:0] cand [N];

  for (genvar g = 0; g < N; g++) begin : g_cand
    assign cand[g] = OW'((int'(ptr) + g) % N);
  end

  // Walk from the farthest candidate to the nearest so that the nearest
  // asserted request is the last one written and therefore wins.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        winner = cand[k];
        valid  = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter_fsm
// Purpose  : Round-robin arbiter with a three-state FSM (IDLE, GRANT,
//            RECOVER). A winner is chosen in IDLE, holds the grant while its
//            request stays high, and the arbiter spends one RECOVER cycle
//            with no grant before arbitrating again.
// Ports    : clk - clock, all state changes on its rising edge
//            rst - asynchronous active-high reset
//            arb - rr_arbiter_fsm_if.slave (req in; grant, owner, busy,
//                  state, timeout out)
// Macro    : RR_ARBITER_TIMEOUT_EN - when defined, a tenure is forcibly
//            ended after MAX_HOLD grant cycles and timeout pulses once.
//            When undefined, tenure is unbounded and timeout stays 0.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter_fsm
  import rr_arb_pkg::*;
#(
  parameter int N        = DEFAULT_N,
  parameter int MAX_HOLD = DEFAULT_MAX_HOLD
) (
  input  logic             clk,
  input  logic             rst,
  rr_arbiter_fsm_if.slave  arb
);

  localparam int OW = idx_w(N);
  localparam logic [OW-1:0] LAST_IDX = OW'(N - 1);

  state_t        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [OW-1:0] ptr_q, ptr_d;
  logic          timeout_q, timeout_d;

  logic [OW-1:0] pick_idx;
  logic          pick_valid;
  logic          hold_done;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req    (arb.req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .valid  (pick_valid)
  );

`ifdef RR_ARBITER_TIMEOUT_EN
  localparam int CW = idx_w(MAX_HOLD);
  localparam logic [CW-1:0] HOLD_LAST = CW'(MAX_HOLD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // The counter is zero in every non-GRANT state, so it is already clear on
  // the first GRANT cycle and counts that cycle as 0.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_GRANT) begin
      cnt_d = hold_done ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hold_done = (cnt_q == HOLD_LAST);
`else
  assign hold_done = 1'b0;

  // MAX_HOLD only matters for the forced-release build.
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
`endif

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    timeout_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          state_d           = S_GRANT;
          grant_d[pick_idx] = 1'b1;
          owner_d           = pick_idx;
          // Start the next search just past the winner so it goes last.
          ptr_d             = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;
        end
      end

      S_GRANT: begin
        // Only the owner's request matters during a tenure.
        if (!arb.req[owner_q]) begin
          state_d = S_RECOVER;
          grant_d = '0;
        end else if (hold_done) begin
          state_d   = S_RECOVER;
          grant_d   = '0;
          timeout_d = 1'b1;
        end
      end

      S_RECOVER: begin
        state_d = S_IDLE;
        grant_d = '0;
      end

      default: begin
        // Unused encoding: fall back to IDLE with the grant cleared.
        state_d = S_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      timeout_q <= timeout_d;
    end
  end

  assign arb.grant   = grant_q;
  assign arb.owner   = owner_q;
  assign arb.state   = state_q;
  assign arb.busy    = (state_q == S_GRANT);
  assign arb.timeout = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_rr_arbiter_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arbiter_fsm
// Purpose  : Self-checking bench for rr_arbiter_fsm (N=4, MAX_HOLD=8).
//            Directed stimulus pushes the hand-computed response expected
//            after the next clock edge into a queue; an independent monitor
//            pops and compares after each edge (or on demand for checks
//            between edges, such as asynchronous reset). Grant one-hotness
//            is checked every cycle.
// Macro    : RR_ARBITER_TIMEOUT_EN selects the forced-release scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arbiter_fsm;
  import rr_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  rr_arbiter_fsm_if #(.N(4)) bus ();

  rr_arbiter_fsm #(
    .N        (4),
    .MAX_HOLD (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .arb (bus)
  );

  typedef struct {
    logic [3:0] grant;
    logic [1:0] owner;
    logic [1:0] state;
    logic       timeout;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   armed = 1'b0;
  event sample_ev;

  task automatic push(input logic [3:0] g, input logic [1:0] o,
                      input logic [1:0] s, input logic t, input string name);
    exp_t e;
    e.grant   = g;
    e.owner   = o;
    e.state   = s;
    e.timeout = t;
    e.name    = name;
    exp_q.push_back(e);
  endtask

  // Apply req (and release reset) at a falling edge; the expectation is for
  // the outputs after the following rising edge.
  task automatic cyc(input logic [3:0] r, input logic [3:0] g,
                     input logic [1:0] o, input logic [1:0] s,
                     input logic t, input string name);
    @(negedge clk);
    rst     = 1'b0;
    bus.req = r;
    push(g, o, s, t, name);
  endtask

  // Raise reset mid-cycle and check its effect before the next rising edge.
  task automatic rst_pulse(input logic [3:0] r, input string name);
    @(negedge clk);
    bus.req = r;
    rst     = 1'b1;
    #2;
    push(4'b0000, 2'd0, S_IDLE, 1'b0, name);
    -> sample_ev;
    #1;
  endtask

  // Scoreboard monitor.
  initial begin
    forever begin
      @(posedge clk or sample_ev);
      #1;
      if (exp_q.size() > 0) begin : chk
        exp_t e;
        e = exp_q.pop_front();
        total++;
        if (bus.grant !== e.grant || bus.owner !== e.owner ||
            bus.state !== e.state || bus.timeout !== e.timeout ||
            bus.busy !== (e.state == 2'b01)) begin
          bad++;
          $display("FAIL %s: got grant=%b owner=%0d state=%b busy=%b timeout=%b, need grant=%b owner=%0d state=%b busy=%b timeout=%b",
                   e.name, bus.grant, bus.owner, bus.state, bus.busy, bus.timeout,
                   e.grant, e.owner, e.state, (e.state == 2'b01), e.timeout);
        end
      end
    end
  end

  // At most one grant bit in every cycle.
  always @(negedge clk) begin
    if (armed) begin
      total++;
      if (!$onehot0(bus.grant)) begin
        bad++;
        $display("FAIL onehot: got grant=%b, need at most one bit set", bus.grant);
      end
    end
  end

  initial begin
    bus.req = 4'b0000;

    // Reset state.
    rst_pulse(4'b0000, "reset_state");
    armed = 1'b1;

    // Two requesters, lowest pointer first, then hand-over via RECOVER/IDLE.
    cyc(4'b0101, 4'b0001, 2'd0, S_GRANT,   1'b0, "first_grant");
    cyc(4'b0101, 4'b0001, 2'd0, S_GRANT,   1'b0, "hold_grant0");
    cyc(4'b0100, 4'b0000, 2'd0, S_RECOVER, 1'b0, "drop0_recover");
    cyc(4'b0100, 4'b0000, 2'd0, S_IDLE,    1'b0, "drop0_idle");
    cyc(4'b0100, 4'b0100, 2'd2, S_GRANT,   1'b0, "grant2");
    cyc(4'b0000, 4'b0000, 2'd2, S_RECOVER, 1'b0, "drop2_recover");
    cyc(4'b0000, 4'b0000, 2'd2, S_IDLE,    1'b0, "drop2_idle");

    // Fresh pointer, all four requesting, each tenure two cycles long.
    rst_pulse(4'b0000, "reset_before_rr");
    for (int k = 0; k < 4; k++) begin
      cyc(4'b1111, 4'(1 << k), 2'(k), S_GRANT, 1'b0, $sformatf("rr%0d_grant", k));
      cyc(4'b1111, 4'(1 << k), 2'(k), S_GRANT, 1'b0, $sformatf("rr%0d_hold", k));
      cyc(4'b1111 ^ 4'(1 << k), 4'b0000, 2'(k), S_RECOVER, 1'b0, $sformatf("rr%0d_recover", k));
      cyc(4'b1111, 4'b0000, 2'(k), S_IDLE, 1'b0, $sformatf("rr%0d_idle", k));
    end
    cyc(4'b1111, 4'b0001, 2'd0, S_GRANT,   1'b0, "rr_wrap_grant0");
    cyc(4'b0000, 4'b0000, 2'd0, S_RECOVER, 1'b0, "rr_wrap_recover");
    cyc(4'b0000, 4'b0000, 2'd0, S_IDLE,    1'b0, "rr_wrap_idle");

    // Asynchronous reset in the middle of a tenure.
    cyc(4'b0011, 4'b0010, 2'd1, S_GRANT, 1'b0, "pre_reset_grant1");
    cyc(4'b0011, 4'b0010, 2'd1, S_GRANT, 1'b0, "pre_reset_hold1");
    rst_pulse(4'b1000, "reset_mid_grant");
    cyc(4'b1000, 4'b1000, 2'd3, S_GRANT,   1'b0, "grant_after_reset");
    cyc(4'b0000, 4'b0000, 2'd3, S_RECOVER, 1'b0, "post_reset_recover");
    cyc(4'b0000, 4'b0000, 2'd3, S_IDLE,    1'b0, "post_reset_idle");

    // Unused state encoding returns to IDLE with the grant cleared.
    cyc(4'b0001, 4'b0001, 2'd0, S_GRANT, 1'b0, "pre_force_grant0");
    @(negedge clk);
    bus.req = 4'b0001;
    force dut.state_q = state_t'(2'b11);
    #1;
    push(4'b0001, 2'd0, 2'b11, 1'b0, "forced_state");
    -> sample_ev;
    #2;
    release dut.state_q;
    push(4'b0000, 2'd0, S_IDLE, 1'b0, "illegal_to_idle");
    cyc(4'b0001, 4'b0001, 2'd0, S_GRANT,   1'b0, "regrant_after_illegal");
    cyc(4'b0000, 4'b0000, 2'd0, S_RECOVER, 1'b0, "illegal_recover");
    cyc(4'b0000, 4'b0000, 2'd0, S_IDLE,    1'b0, "illegal_idle");

    // Long tenure for requester 1.
    cyc(4'b0010, 4'b0010, 2'd1, S_GRANT, 1'b0, "long_grant1");
`ifdef RR_ARBITER_TIMEOUT_EN
    for (int k = 1; k < 8; k++) begin
      cyc(4'b0010, 4'b0010, 2'd1, S_GRANT, 1'b0, $sformatf("long_hold%0d", k));
    end
    cyc(4'b0010, 4'b0000, 2'd1, S_RECOVER, 1'b1, "timeout_recover");
    cyc(4'b0010, 4'b0000, 2'd1, S_IDLE,    1'b0, "timeout_idle");
    cyc(4'b0010, 4'b0010, 2'd1, S_GRANT,   1'b0, "timeout_regrant1");
`else
    for (int k = 1; k < 12; k++) begin
      cyc(4'b0010, 4'b0010, 2'd1, S_GRANT, 1'b0, $sformatf("long_hold%0d", k));
    end
`endif
    cyc(4'b0000, 4'b0000, 2'd1, S_RECOVER, 1'b0, "long_recover");
    cyc(4'b0000, 4'b0000, 2'd1, S_IDLE,    1'b0, "long_idle");

    // Every pushed expectation must have been consumed.
    repeat (3) @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rr_arbiter_fsm.md
RR_ARBITER_FSM -- requirements
Module: rr_arbiter_fsm

Interface
REQ-001 The block SHALL have parameter N, default 4, meaning the number of requesters (2..8).
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, meaning the maximum number of GRANT cycles per tenure (used only with TIMEOUT_EN).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-005 The block SHALL have port req, input, N, with one request line per requester; level-held while the requester wants the resource.
REQ-006 The block SHALL have port grant, output reg, N: one-hot (or zero) registered grant.
REQ-007 The block SHALL have port owner, output reg, clog2(N): index of the current or last granted requester.
REQ-008 The block SHALL have port busy, output, 1: high exactly when state is GRANT.
REQ-009 The block SHALL have port state, output reg, 2: current FSM state, for observation.
REQ-010 The block SHALL have port timeout, output reg, 1: one-cycle pulse on a forced release (held 0 without TIMEOUT_EN).

Function
REQ-011 The FSM SHALL have states IDLE=2'b00, GRANT=2'b01 and RECOVER=2'b10; code 2'b11 SHALL go to IDLE on the next edge with grant=0.
REQ-012 In IDLE with req==0, the FSM SHALL stay in IDLE with grant=0.
REQ-013 In IDLE with req!=0, the winner SHALL be the first asserted req[i], searching i=ptr, ptr+1, ... mod N; on the next edge state=GRANT, grant=onehot(winner), owner=winner, ptr=(winner+1) mod N.
REQ-014 Grant latency SHALL be one edge: req sampled at edge k gives grant visible after edge k.
REQ-015 In GRANT, the FSM SHALL hold grant and owner unchanged while req[owner]=1; other req lines SHALL be ignored.
REQ-016 In GRANT with req[owner]=0 at an edge, the FSM SHALL go to RECOVER with grant cleared at that same edge.
REQ-017 RECOVER SHALL last exactly one cycle with grant=0, then go to IDLE regardless of req.
REQ-018 A requester that dropped and re-raised req SHALL compete again only via IDLE; the pointer guarantees every other pending requester is served before it.
REQ-019 The arbiter SHALL keep at most one grant bit high in every cycle.

Reset
REQ-020 On rst=1, the block SHALL immediately (asynchronously) set state=IDLE, grant=0, owner=0, ptr=0, hold counter=0 and timeout=0.
REQ-021 If rst asserts during GRANT, grant SHALL drop without passing through RECOVER; after release, arbitration SHALL restart from ptr=0.

Configuration
REQ-022 With macro RR_ARBITER_TIMEOUT_EN defined, an up-counter SHALL clear on entry to GRANT and increment each GRANT cycle; when it equals MAX_HOLD-1 and req[owner]=1, the next edge SHALL force GRANT->RECOVER, clear grant and pulse timeout for one cycle.
REQ-023 With the macro undefined, the block SHALL omit the counter, keep timeout at 0 and allow unbounded tenure.

Structure
REQ-024 The package rr_arb_pkg SHALL hold the state encodings (S_IDLE, S_GRANT, S_RECOVER) and the default N and MAX_HOLD constants.
REQ-025 The block SHALL have one combinational sub-module, rr_pick (inputs req and ptr; outputs winner index and a valid flag); the FSM and counter SHALL remain in the top module.

Verification
REQ-026 Scenario: N=4, reset, then req=4'b0101 held -> grant=0001 after the first edge, owner=0, ptr=1.
REQ-027 Scenario: from REQ-026, drop req[0] -> GRANT->RECOVER (grant=0) -> IDLE -> grant=0100, owner=2.
REQ-028 Scenario: req=4'b1111 with each owner releasing after 2 cycles -> grant order 0001, 0010, 0100, 1000, 0001, with 2 idle cycles (RECOVER, IDLE) between tenures.
REQ-029 Scenario: with TIMEOUT_EN and MAX_HOLD=8, req=4'b0010 held -> grant high for exactly 8 cycles, timeout pulses once, then re-grant to requester 1 after RECOVER and IDLE.
REQ-030 Scenario: rst asserted mid-GRANT between clock edges -> grant=0 and state=00 before the next edge; on release with req=4'b1000, grant=1000 after one edge.
REQ-031 Scenario: force state to 2'b11 -> IDLE at the next edge, grant=0; a one-hot check on grant is asserted in every cycle of every scenario.
